imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Boot-time program writer for the instruction memory that the fetch unit reads.
//   Accepts a byte stream on a valid/ready interface. The first two bytes are a
//   16-bit little-endian word count N, followed by 4*N bytes. Each little-endian
//   32-bit instruction is written to consecutive word addresses starting at 0.
//   The core is held in reset (cpu_reset) until the whole program has been written.
// PARAMETERS
//   MEM_WORDS   256   instruction memory depth in 32-bit words
//   ADDR_W      8     word-address width; must satisfy 2**ADDR_W >= MEM_WORDS
// PORTS
//   clock      in   1       single clock; all logic on the rising edge
//   reset      in   1       synchronous, active-high
//   in_valid   in   1       byte-stream valid
//   in_data    in   8       byte-stream data
//   in_ready   out  1       loader can accept a byte this cycle
//   mem_we     out  1       instruction-memory write strobe (one cycle per word)
//   mem_addr   out  ADDR_W  word address for the write
//   mem_wdata  out  32      instruction word for the write
//   cpu_reset  out  1       holds the processor in reset while high
//   done       out  1       program fully loaded (sticky)
//   error      out  1       word count exceeded MEM_WORDS (sticky)
// BEHAVIOUR
//   Reset: state=LEN0; in_ready=0 on the reset cycle, then 1; mem_we=0; mem_addr=0;
//     mem_wdata=0; cpu_reset=1; done=0; error=0; byte_idx=0; word counter=0.
//   Handshake: a byte is accepted on any rising edge where in_valid && in_ready.
//     in_data is sampled only on accept. in_ready is registered-free and equals
//     (state is LEN0, LEN1 or DATA).
//   FSM:
//     LEN0 --accept--> LEN1   latch N[7:0]
//     LEN1 --accept--> N==0         : DONE
//                      N>MEM_WORDS  : ERR
//                      else         : DATA   (latch N[15:8] first)
//     DATA: byte k of a word fills bits [8k+7:8k], k=0..3.
//       On the accept of byte 3, the next cycle has mem_we=1, mem_wdata=the
//       assembled word and mem_addr=the current word index (1-cycle latency).
//       After that write cycle, the word index increments.
//       On the accept of the final byte of word N-1 -> DONE.
//     DONE: done=1, cpu_reset=0 from the cycle after the final write cycle.
//       For N==0, this is the cycle after the LEN1 accept. DONE is terminal.
//     ERR: error=1, cpu_reset stays 1. ERR is terminal.
//   mem_we is high for exactly one cycle per word, so there are N write pulses in
//     total. mem_addr and mem_wdata hold their last values when mem_we=0.
//   The word index never wraps, because N<=MEM_WORDS is checked up front.
//     N==MEM_WORDS is legal and the last address written is MEM_WORDS-1.
//   Gaps: in_valid may drop between any bytes. Partial-word state is retained
//     indefinitely.
//   A write cycle and the next accept can occur back-to-back. The loader sustains
//     1 byte per cycle with no bubbles.
//   In DONE or ERR, in_valid is ignored and no further mem_we pulses occur.
//   Reset mid-load: partial state is discarded, FSM returns to LEN0 and
//     cpu_reset=1. Memory contents are untouched.
// TESTING
//   1. Stream 01 00 13 05 A0 00 at 1 byte/cycle -> one mem_we with addr=0 and
//      wdata=0x00A00513; done=1 and cpu_reset=0 on the next cycle.
//   2. N=3 with random in_valid gaps -> writes to addr 0,1,2 with correct words,
//      exactly 3 mem_we pulses; in_ready=0 after done.
//   3. Header 00 00 -> no mem_we; done=1 and cpu_reset=0 one cycle after the 2nd
//      byte is accepted.
//   4. Header N=MEM_WORDS+1 (01 01 with defaults) -> error=1, cpu_reset=1,
//      in_ready=0, no mem_we; N=MEM_WORDS -> last write at addr MEM_WORDS-1.
//   5. Assert reset after 2 of 4 bytes of word 1 -> state LEN0, cpu_reset=1.
//      A reload with N=1 then writes addr 0 with the new word.
//   6. Bytes held on in_data while in_valid=0 -> not accepted and no write.
//      Extra bytes after done -> ignored.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time program writer for the instruction memory read by the fetch unit.
//   A byte stream arrives on a valid/ready handshake. The first two bytes are a
//   little-endian 16-bit word count N. They are followed by 4*N bytes, which form
//   little-endian 32-bit instructions. The instructions are written to word
//   addresses 0..N-1. The processor is held in reset until the whole program has
//   been written.
//
// Ports
//   clock      in   1       rising-edge clock
//   reset      in   1       synchronous, active-high
//   in_valid   in   1       byte-stream valid
//   in_data    in   8       byte-stream data
//   in_ready   out  1       loader can take a byte this cycle
//   mem_we     out  1       instruction-memory write strobe, one cycle per word
//   mem_addr   out  ADDR_W  word address of the write
//   mem_wdata  out  32      instruction word of the write
//   cpu_reset  out  1       holds the processor in reset while high
//   done       out  1       program fully loaded (sticky)
//   error      out  1       word count exceeded MEM_WORDS (sticky)
module imem_loader #(
  parameter int MEM_WORDS = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    LEN0,
    LEN1,
    DATA,
    DONE,
    ERR
  } state_t;

  state_t      state;
  state_t      next_state;

  logic        accept;
  logic [7:0]  n_lo;
  logic [15:0] n_words;
  logic [15:0] n_full;
  logic [1:0]  byte_idx;
  logic [15:0] word_idx;
  logic [23:0] partial;
  logic        last_byte;

  assign accept = in_valid && in_ready;

  // Full count as seen while the high byte is being accepted.
  assign n_full = {in_data, n_lo};

  // True while the byte on offer would complete the final word.
  assign last_byte = (byte_idx == 2'd3) && (word_idx == n_words - 16'd1);

  // The state register holds the position in the stream.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= LEN0;
    end else begin
      state <= next_state;
    end
  end

  // The stream moves through the header, then the data, then parks in a
  // terminal state. The size check is made up front, so the word index
  // can never run past the end of memory.
  always_comb begin
    next_state = state;
    case (state)
      LEN0: begin
        if (accept) next_state = LEN1;
      end
      LEN1: begin
        if (accept) begin
          if (n_full == 16'd0) begin
            next_state = DONE;
          end else if (int'({16'd0, n_full}) > MEM_WORDS) begin
            next_state = ERR;
          end else begin
            next_state = DATA;
          end
        end
      end
      DATA: begin
        if (accept && last_byte) next_state = DONE;
      end
      default: next_state = state;
    endcase
  end

  // Status outputs are decoded from the state. DONE is entered together with
  // the final write cycle, so done is held off while that write is still on
  // the bus. The CPU is released only once done is asserted.
  always_comb begin
    in_ready  = !reset && ((state == LEN0) || (state == LEN1) || (state == DATA));
    done      = !reset && (state == DONE) && !mem_we;
    error     = !reset && (state == ERR);
    cpu_reset = !done;
  end

  // The datapath latches the count and assembles each word byte by byte.
  // On byte 3 it issues the registered write. The write and the next
  // accept can share a cycle, so the stream runs at one byte per cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      n_lo      <= '0;
      n_words   <= '0;
      byte_idx  <= '0;
      word_idx  <= '0;
      partial   <= '0;
    end else begin
      mem_we <= 1'b0;
      if (accept) begin
        case (state)
          LEN0: n_lo <= in_data;
          LEN1: n_words <= n_full;
          DATA: begin
            case (byte_idx)
              2'd0: partial[7:0]   <= in_data;
              2'd1: partial[15:8]  <= in_data;
              2'd2: partial[23:16] <= in_data;
              default: begin
                mem_we    <= 1'b1;
                mem_addr  <= word_idx[ADDR_W-1:0];
                mem_wdata <= {in_data, partial};
                word_idx  <= word_idx + 16'd1;
              end
            endcase
            byte_idx <= byte_idx + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Directed self-checking bench for imem_loader. Each scenario task drives a
//   byte stream and compares the DUT outputs against hand-computed values.
//   A negedge monitor records every write pulse into queues.
module tb_imem_loader;

  localparam int MEM_WORDS = 256;
  localparam int ADDR_W    = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;

  int checks   = 0;
  int failures = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];

  imem_loader #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset),
    .done     (done),
    .error    (error)
  );

  always #5 clock = ~clock;

  // Record every write pulse seen outside reset.
  always @(negedge clock) begin
    if (!reset && mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Offer one byte and return 1 ns after the edge that accepts it.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clock);
    while (!in_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL send_byte_timeout: in_ready stayed %0b, expected 1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_gap(input logic [7:0] b, input int gap);
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(posedge clock);
      #1;
    end
    send_byte(b);
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    send_gap(w[7:0],   $urandom_range(0, max_gap));
    send_gap(w[15:8],  $urandom_range(0, max_gap));
    send_gap(w[23:16], $urandom_range(0, max_gap));
    send_gap(w[31:24], $urandom_range(0, max_gap));
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_in_ready: got %0b expected 0", in_ready); end
    checks++; if (cpu_reset !== 1'b1) begin failures++; $display("[TB] FAIL rst_cpu_reset: got %0b expected 1", cpu_reset); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_mem_we: got %0b expected 0", mem_we); end
    checks++; if (mem_addr !== 8'h00) begin failures++; $display("[TB] FAIL rst_mem_addr: got %h expected 00", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("[TB] FAIL rst_mem_wdata: got %h expected 0", mem_wdata); end
    checks++; if ({done, error} !== 2'b00) begin failures++; $display("[TB] FAIL rst_done_error: got %b expected 00", {done, error}); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clock);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_release_ready: got %0b expected 1", in_ready); end
    checks++; if (cpu_reset !== 1'b1) begin failures++; $display("[TB] FAIL rst_release_cpu: got %0b expected 1", cpu_reset); end
  endtask

  task automatic test_single_word();
    do_reset();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
    in_valid = 1'b0;
    @(negedge clock);
    checks++; if (mem_we !== 1'b1) begin failures++; $display("[TB] FAIL t1_we: got %0b expected 1", mem_we); end
    checks++; if (mem_addr !== 8'h00) begin failures++; $display("[TB] FAIL t1_addr: got %h expected 00", mem_addr); end
    checks++; if (mem_wdata !== 32'h00A00513) begin failures++; $display("[TB] FAIL t1_wdata: got %h expected 00a00513", mem_wdata); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL t1_done_early: got %0b expected 0", done); end
    @(negedge clock);
    checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL t1_done: got %0b expected 1", done); end
    checks++; if (cpu_reset !== 1'b0) begin failures++; $display("[TB] FAIL t1_cpu_reset: got %0b expected 0", cpu_reset); end
    idle(3);
    checks++; if (wr_addr_q.size() !== 1) begin failures++; $display("[TB] FAIL t1_count: got %0d expected 1", wr_addr_q.size()); end
  endtask

  task automatic test_gaps();
    logic [31:0] words [3];
    words[0] = 32'h11223344;
    words[1] = 32'hDEADBEEF;
    words[2] = 32'h00000013;
    do_reset();
    send_gap(8'h03, $urandom_range(0, 3));
    send_gap(8'h00, $urandom_range(0, 3));
    for (int i = 0; i < 3; i++) send_word(words[i], 3);
    in_valid = 1'b0;
    idle(4);
    checks++; if (wr_addr_q.size() !== 3) begin failures++; $display("[TB] FAIL t2_count: got %0d expected 3", wr_addr_q.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < wr_addr_q.size()) begin
        checks++; if (wr_addr_q[i] !== 8'(i)) begin failures++; $display("[TB] FAIL t2_addr%0d: got %h expected %h", i, wr_addr_q[i], 8'(i)); end
        checks++; if (wr_data_q[i] !== words[i]) begin failures++; $display("[TB] FAIL t2_data%0d: got %h expected %h", i, wr_data_q[i], words[i]); end
      end
    end
    checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL t2_done: got %0b expected 1", done); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL t2_ready_after_done: got %0b expected 0", in_ready); end
  endtask

  task automatic test_zero_count();
    do_reset();
    send_byte(8'h00); send_byte(8'h00);
    in_valid = 1'b0;
    @(negedge clock);
    checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL t3_done: got %0b expected 1", done); end
    checks++; if (cpu_reset !== 1'b0) begin failures++; $display("[TB] FAIL t3_cpu_reset: got %0b expected 0", cpu_reset); end
    idle(3);
    checks++; if (wr_addr_q.size() !== 0) begin failures++; $display("[TB] FAIL t3_count: got %0d expected 0", wr_addr_q.size()); end
  endtask

  task automatic test_overflow();
    do_reset();
    send_byte(8'h01); send_byte(8'h01);
    in_valid = 1'b0;
    @(negedge clock);
    checks++; if (error !== 1'b1) begin failures++; $display("[TB] FAIL t4_error: got %0b expected 1", error); end
    checks++; if (cpu_reset !== 1'b1) begin failures++; $display("[TB] FAIL t4_cpu_reset: got %0b expected 1", cpu_reset); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL t4_ready: got %0b expected 0", in_ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL t4_done: got %0b expected 0", done); end
    in_valid = 1'b1;
    in_data  = 8'h55;
    idle(6);
    in_valid = 1'b0;
    idle(2);
    checks++; if (wr_addr_q.size() !== 0) begin failures++; $display("[TB] FAIL t4_count: got %0d expected 0", wr_addr_q.size()); end
    checks++; if (error !== 1'b1) begin failures++; $display("[TB] FAIL t4_error_sticky: got %0b expected 1", error); end
  endtask

  task automatic test_full_depth();
    int bad;
    logic [31:0] w;
    do_reset();
    send_byte(8'h00); send_byte(8'h01);
    for (int i = 0; i < MEM_WORDS; i++) begin
      w = {8'(i), 8'hA5, 8'(i) ^ 8'hFF, 8'h5A};
      send_word(w, 0);
    end
    in_valid = 1'b0;
    @(negedge clock);
    checks++; if (mem_we !== 1'b1) begin failures++; $display("[TB] FAIL t4b_we: got %0b expected 1", mem_we); end
    checks++; if (mem_addr !== 8'hFF) begin failures++; $display("[TB] FAIL t4b_last_addr: got %h expected ff", mem_addr); end
    checks++; if (mem_wdata !== 32'hFFA5005A) begin failures++; $display("[TB] FAIL t4b_last_data: got %h expected ffa5005a", mem_wdata); end
    idle(3);
    checks++; if (wr_addr_q.size() !== MEM_WORDS) begin failures++; $display("[TB] FAIL t4b_count: got %0d expected %0d", wr_addr_q.size(), MEM_WORDS); end
    bad = 0;
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      w = {8'(i), 8'hA5, 8'(i) ^ 8'hFF, 8'h5A};
      if (wr_addr_q[i] !== 8'(i) || wr_data_q[i] !== w) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("[TB] FAIL t4b_contents: got %0d bad writes expected 0", bad); end
    checks++; if ({done, cpu_reset} !== 2'b10) begin failures++; $display("[TB] FAIL t4b_done: got %b expected 10", {done, cpu_reset}); end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    send_byte(8'h02); send_byte(8'h00);
    send_word(32'h0A0B0C0D, 0);
    send_byte(8'hEE); send_byte(8'hFF);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clock);
    checks++; if (cpu_reset !== 1'b1) begin failures++; $display("[TB] FAIL t5_cpu_reset: got %0b expected 1", cpu_reset); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL t5_ready_in_reset: got %0b expected 0", in_ready); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clock);
    checks++; if ({in_ready, cpu_reset, done} !== 3'b110) begin failures++; $display("[TB] FAIL t5_after_reset: got %b expected 110", {in_ready, cpu_reset, done}); end
    @(posedge clock);
    #1;
    send_byte(8'h01); send_byte(8'h00);
    send_word(32'h12345678, 0);
    in_valid = 1'b0;
    @(negedge clock);
    checks++; if (mem_we !== 1'b1) begin failures++; $display("[TB] FAIL t5_we: got %0b expected 1", mem_we); end
    checks++; if (mem_addr !== 8'h00) begin failures++; $display("[TB] FAIL t5_addr: got %h expected 00", mem_addr); end
    checks++; if (mem_wdata !== 32'h12345678) begin failures++; $display("[TB] FAIL t5_wdata: got %h expected 12345678", mem_wdata); end
    idle(3);
    checks++; if (wr_addr_q.size() !== 1) begin failures++; $display("[TB] FAIL t5_count: got %0d expected 1", wr_addr_q.size()); end
    checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL t5_done: got %0b expected 1", done); end
  endtask

  task automatic test_invalid_and_extra();
    do_reset();
    send_byte(8'h01); send_byte(8'h00);
    in_valid = 1'b0;
    in_data  = 8'h77;
    idle(5);
    checks++; if (wr_addr_q.size() !== 0) begin failures++; $display("[TB] FAIL t6_no_write: got %0d expected 0", wr_addr_q.size()); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL t6_waiting: got %0b expected 1", in_ready); end
    send_word(32'h00000073, 0);
    in_valid = 1'b0;
    idle(2);
    checks++; if (wr_addr_q.size() !== 1) begin failures++; $display("[TB] FAIL t6_count: got %0d expected 1", wr_addr_q.size()); end
    if (wr_data_q.size() > 0) begin
      checks++; if (wr_data_q[0] !== 32'h00000073) begin failures++; $display("[TB] FAIL t6_data: got %h expected 00000073", wr_data_q[0]); end
    end
    in_valid = 1'b1;
    in_data  = 8'h99;
    idle(5);
    in_valid = 1'b0;
    idle(2);
    checks++; if (wr_addr_q.size() !== 1) begin failures++; $display("[TB] FAIL t6_extra_ignored: got %0d expected 1", wr_addr_q.size()); end
    checks++; if ({done, in_ready, cpu_reset} !== 3'b100) begin failures++; $display("[TB] FAIL t6_final: got %b expected 100", {done, in_ready, cpu_reset}); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_gaps();
    test_zero_count();
    test_overflow();
    test_full_depth();
    test_reset_mid_load();
    test_invalid_and_extra();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
